alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/bcd2_counter.sv | 45 ++++
 rtl/alarm_ctrl.sv | 135 +++++++++++++
 tb/tb_alarm_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared definitions for the alarm controller slice: the FSM state
// encoding shown on the front-panel LEDs, the BCD digit width, and a
// helper that sizes the seconds counters.
package alarm_pkg;

  // Width of one BCD digit on every time/alarm port.
  localparam int BCD_W = 4;

  // LED-visible state codes; code 3 is unused and treated as illegal.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter
// Two-digit BCD up-counter that wraps from MAX back to 00. It is used
// for the alarm hour (MAX=23) and the alarm minute (MAX=59).
// Ports:
//   clk50  in  system clock
//   reset  in  synchronous active-high reset, clears to 00
//   inc    in  one-cycle increment request
//   tens   out tens digit (BCD)
//   ones   out ones digit (BCD)
module bcd2_counter
  import alarm_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX / 10);
  localparam logic [BCD_W-1:0] MAX_O = BCD_W'(MAX % 10);

  // The counter only ever steps by one from 00, so checking the wrap
  // point first and then the ones-digit rollover keeps both digits in
  // valid BCD at all times (e.g. 19 -> 20 for hours, 59 -> 00 minutes).
  always_ff @(posedge clk50) begin
    if (reset) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (tens == MAX_T && ones == MAX_O) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == BCD_W'(9)) begin
        ones <= '0;
        tens <= tens + 1'b1;
      end else begin
        ones <= ones + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl
// Alarm clock controller: stores an editable alarm time, detects the
// rising edge of "current time equals alarm time at :00 seconds", and
// runs a ring / snooze FSM timed by the 1 Hz tick.
// Ports:
//   clk50                         in  50 MHz system clock
//   reset                         in  synchronous active-high reset
//   tick_1hz                      in  one-cycle pulse per second
//   hr_t,hr_o,min_t,min_o,sec_t,sec_o  in  current time, BCD
//   alarm_en                      in  level, 0 disables and forces IDLE
//   set_mode                      in  level, 1 allows alarm editing
//   inc_h, inc_m                  in  key pulses, bump alarm hour/minute
//   stop, snooze                  in  key pulses
//   alm_h_t,alm_h_o,alm_m_t,alm_m_o   out stored alarm time, BCD
//   ring                          out high while ringing
//   state                         out encoded FSM state for the LEDs
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic [BCD_W-1:0] hr_t,
  input  logic [BCD_W-1:0] hr_o,
  input  logic [BCD_W-1:0] min_t,
  input  logic [BCD_W-1:0] min_o,
  input  logic [BCD_W-1:0] sec_t,
  input  logic [BCD_W-1:0] sec_o,
  input  logic             alarm_en,
  input  logic             set_mode,
  input  logic             inc_h,
  input  logic             inc_m,
  input  logic             stop,
  input  logic             snooze,
  output logic [BCD_W-1:0] alm_h_t,
  output logic [BCD_W-1:0] alm_h_o,
  output logic [BCD_W-1:0] alm_m_t,
  output logic [BCD_W-1:0] alm_m_o,
  output logic             ring,
  output logic [1:0]       state
);

  localparam int RW = cnt_width(RING_SEC);
  localparam int SW = cnt_width(SNOOZE_SEC);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);

  alarm_state_t  state_q, state_d;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic          match, match_q, trigger;

  // Alarm time storage; editing keys are only honoured in set mode.
  bcd2_counter #(.MAX(23)) u_hour (
    .clk50 (clk50),
    .reset (reset),
    .inc   (inc_h & set_mode),
    .tens  (alm_h_t),
    .ones  (alm_h_o)
  );

  bcd2_counter #(.MAX(59)) u_min (
    .clk50 (clk50),
    .reset (reset),
    .inc   (inc_m & set_mode),
    .tens  (alm_m_t),
    .ones  (alm_m_o)
  );

  // Time equals alarm at the start of the minute. Editing or a disabled
  // alarm suppresses the match so adjusting the alarm never fires it.
  always_comb begin
    match = alarm_en && !set_mode &&
            hr_t == alm_h_t && hr_o == alm_h_o &&
            min_t == alm_m_t && min_o == alm_m_o &&
            sec_t == '0 && sec_o == '0;
    trigger = match && !match_q;
  end

  // Next-state logic. Stop is checked before snooze so it wins when both
  // keys land together; triggers outside IDLE fall through unused. The
  // enable/set-mode override is applied last so it beats everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) state_d = ST_RINGING;
      end
      ST_RINGING: begin
        if (stop)                                state_d = ST_IDLE;
        else if (snooze)                         state_d = ST_SNOOZED;
        else if (tick_1hz && ring_cnt == RING_LAST) state_d = ST_IDLE;
      end
      ST_SNOOZED: begin
        if (stop)                                state_d = ST_IDLE;
        else if (tick_1hz && snz_cnt == SNZ_LAST) state_d = ST_RINGING;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!alarm_en || set_mode) state_d = ST_IDLE;
  end

  // State register, match history and the seconds counters. A counter
  // only advances while its state persists across the edge, so any entry
  // into or exit from RINGING/SNOOZED starts the next period from zero.
  // match_q resets high so a 00:00:00 time right after reset can't fire.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      match_q  <= 1'b1;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match;
      if (state_q == ST_RINGING && state_d == ST_RINGING) begin
        if (tick_1hz) ring_cnt <= ring_cnt + 1'b1;
      end else begin
        ring_cnt <= '0;
      end
      if (state_q == ST_SNOOZED && state_d == ST_SNOOZED) begin
        if (tick_1hz) snz_cnt <= snz_cnt + 1'b1;
      end else begin
        snz_cnt <= '0;
      end
    end
  end

  assign ring  = (state_q == ST_RINGING);
  assign state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl
// Drives two alarm_ctrl instances in parallel (default timing and a
// short RING_SEC=4 / SNOOZE_SEC=3 build) from the same inputs and
// compares them against a behavioural model that tracks the alarm as an
// hour/minute pair and the ring/snooze periods as elapsed seconds.
module tb_alarm_ctrl;

  logic       clk50, reset, tick_1hz, alarm_en, set_mode;
  logic       inc_h, inc_m, stop, snooze;
  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
  logic [3:0] aht[2], aho[2], amt[2], amo[2];
  logic       ring_o[2];
  logic [1:0] state_o[2];

  int vectors;
  int miscompares;

  int cur_h, cur_m, cur_s;
  int al_h, al_m;
  bit prev_match;
  int m_mode[2];
  int m_rsec[2];
  int m_ssec[2];
  int ring_lim[2] = '{60, 4};
  int snz_lim[2]  = '{300, 3};

  alarm_ctrl dut_full (
    .clk50(clk50), .reset(reset), .tick_1hz(tick_1hz),
    .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o),
    .sec_t(sec_t), .sec_o(sec_o), .alarm_en(alarm_en),
    .set_mode(set_mode), .inc_h(inc_h), .inc_m(inc_m),
    .stop(stop), .snooze(snooze),
    .alm_h_t(aht[0]), .alm_h_o(aho[0]), .alm_m_t(amt[0]), .alm_m_o(amo[0]),
    .ring(ring_o[0]), .state(state_o[0])
  );

  alarm_ctrl #(.RING_SEC(4), .SNOOZE_SEC(3)) dut_small (
    .clk50(clk50), .reset(reset), .tick_1hz(tick_1hz),
    .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o),
    .sec_t(sec_t), .sec_o(sec_o), .alarm_en(alarm_en),
    .set_mode(set_mode), .inc_h(inc_h), .inc_m(inc_m),
    .stop(stop), .snooze(snooze),
    .alm_h_t(aht[1]), .alm_h_o(aho[1]), .alm_m_t(amt[1]), .alm_m_o(amo[1]),
    .ring(ring_o[1]), .state(state_o[1])
  );

  // 50 MHz clock.
  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  // Behavioural model: 0 = idle, 1 = ringing, 2 = snoozed, with elapsed
  // seconds in each period compared against the configured lengths.
  function automatic void model_update();
    bit match, trig;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_rsec[k] = 0; m_ssec[k] = 0;
      end
      al_h = 0; al_m = 0; prev_match = 1'b1;
      return;
    end
    match = alarm_en && !set_mode && cur_h == al_h && cur_m == al_m && cur_s == 0;
    trig = match && !prev_match;
    prev_match = match;
    for (int k = 0; k < 2; k++) begin
      if (!alarm_en || set_mode) m_mode[k] = 0;
      else if (m_mode[k] == 0) begin
        if (trig) begin m_mode[k] = 1; m_rsec[k] = 0; end
      end else if (m_mode[k] == 1) begin
        if (stop) m_mode[k] = 0;
        else if (snooze) begin m_mode[k] = 2; m_ssec[k] = 0; end
        else if (tick_1hz) begin
          m_rsec[k]++;
          if (m_rsec[k] == ring_lim[k]) m_mode[k] = 0;
        end
      end else begin
        if (stop) m_mode[k] = 0;
        else if (tick_1hz) begin
          m_ssec[k]++;
          if (m_ssec[k] == snz_lim[k]) begin m_mode[k] = 1; m_rsec[k] = 0; end
        end
      end
    end
    if (set_mode && inc_h) al_h = (al_h + 1) % 24;
    if (set_mode && inc_m) al_m = (al_m + 1) % 60;
  endfunction

  // One clock: the model sees the same inputs the DUTs sampled.
  task automatic step();
    @(posedge clk50);
    model_update();
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    hr_t = 4'(h / 10); hr_o = 4'(h % 10);
    min_t = 4'(m / 10); min_o = 4'(m % 10);
    sec_t = 4'(s / 10); sec_o = 4'(s % 10);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== 2'd0 || ring_o[k] !== 1'b0 ||
          {aht[k], aho[k], amt[k], amo[k]} !== 16'h0000) begin
        miscompares++;
        $display("[TB] FAIL reset inst%0d: state=%0d ring=%b alarm=%h, expected 0 0 0000",
                 k, state_o[k], ring_o[k], {aht[k], aho[k], amt[k], amo[k]});
      end
    end
    alarm_en = 1'b1;
    set_time(0, 0, 0);
    repeat (3) begin
      step();
      vectors++;
      if (ring_o[0] !== 1'b0 || ring_o[1] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_no_trigger: ring=%b/%b, expected 0/0", ring_o[0], ring_o[1]);
      end
    end
  endtask

  task automatic test_trigger();
    set_mode = 1'b1;
    repeat (6)  begin inc_h = 1'b1; step(); inc_h = 1'b0; step(); end
    repeat (30) begin inc_m = 1'b1; step(); inc_m = 1'b0; step(); end
    set_mode = 1'b0;
    vectors++;
    if ({aht[0], aho[0], amt[0], amo[0]} !== 16'h0630) begin
      miscompares++;
      $display("[TB] FAIL alarm_set: alarm=%h, expected 0630", {aht[0], aho[0], amt[0], amo[0]});
    end
    set_time(6, 29, 59); step();
    vectors++;
    if (state_o[0] !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL pre_match: state=%0d, expected 0", state_o[0]);
    end
    set_time(6, 30, 0); step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ring_o[k] !== 1'b1 || state_o[k] !== 2'd1) begin
        miscompares++;
        $display("[TB] FAIL trigger inst%0d: ring=%b state=%0d, expected 1 1", k, ring_o[k], state_o[k]);
      end
    end
  endtask

  task automatic test_auto_stop();
    for (int i = 1; i <= 60; i++) begin
      pulse_tick();
      vectors++;
      if (ring_o[0] !== (i < 60)) begin
        miscompares++;
        $display("[TB] FAIL auto_stop tick %0d: ring=%b, expected %b", i, ring_o[0], (i < 60));
      end
      step();
    end
    repeat (5) step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== 2'd0 || ring_o[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL no_retrigger inst%0d: state=%0d ring=%b, expected 0 0", k, state_o[k], ring_o[k]);
      end
    end
  endtask

  task automatic test_snooze();
    set_time(6, 30, 1); step();
    set_time(6, 30, 0); step();
    repeat (2) begin pulse_tick(); step(); end
    snooze = 1'b1; step(); snooze = 1'b0;
    vectors++;
    if (state_o[1] !== 2'd2 || ring_o[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL snooze: state=%0d ring=%b, expected 2 0", state_o[1], ring_o[1]);
    end
    for (int i = 1; i <= 3; i++) begin
      pulse_tick();
      vectors++;
      if (state_o[1] !== ((i < 3) ? 2'd2 : 2'd1)) begin
        miscompares++;
        $display("[TB] FAIL snooze_tick %0d: state=%0d, expected %0d", i, state_o[1], (i < 3) ? 2 : 1);
      end
      step();
    end
    for (int i = 1; i <= 4; i++) begin
      pulse_tick();
      vectors++;
      if (ring_o[1] !== (i < 4)) begin
        miscompares++;
        $display("[TB] FAIL rering tick %0d: ring=%b, expected %b", i, ring_o[1], (i < 4));
      end
      step();
    end
    vectors++;
    if (state_o[0] !== 2'(m_mode[0])) begin
      miscompares++;
      $display("[TB] FAIL snooze_full: state=%0d, expected %0d", state_o[0], m_mode[0]);
    end
  endtask

  task automatic test_stop_wins();
    set_time(6, 30, 1); step();
    set_time(6, 30, 0); step();
    vectors++;
    if (state_o[1] !== 2'd1 || state_o[0] !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL retrigger: state=%0d/%0d, expected 2/1", state_o[0], state_o[1]);
    end
    stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL stop_wins inst%0d: state=%0d, expected 0", k, state_o[k]);
      end
    end
  endtask

  task automatic test_set_mode();
    inc_h = 1'b1; inc_m = 1'b1; step(); inc_h = 1'b0; inc_m = 1'b0;
    vectors++;
    if ({aht[0], aho[0], amt[0], amo[0]} !== 16'h0630) begin
      miscompares++;
      $display("[TB] FAIL inc_gated: alarm=%h, expected 0630", {aht[0], aho[0], amt[0], amo[0]});
    end
    set_time(6, 30, 1); step();
    set_time(6, 30, 0); step();
    set_mode = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (state_o[k] !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL set_mode_idle inst%0d: state=%0d, expected 0", k, state_o[k]);
      end
    end
    repeat (17) begin inc_h = 1'b1; step(); inc_h = 1'b0; step(); end
    repeat (29) begin inc_m = 1'b1; step(); inc_m = 1'b0; step(); end
    vectors++;
    if ({aht[1], aho[1], amt[1], amo[1]} !== 16'h2359) begin
      miscompares++;
      $display("[TB] FAIL alarm_2359: alarm=%h, expected 2359", {aht[1], aho[1], amt[1], amo[1]});
    end
    inc_h = 1'b1; inc_m = 1'b1; step(); inc_h = 1'b0; inc_m = 1'b0;
    vectors++;
    if ({aht[0], aho[0], amt[0], amo[0]} !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL wrap_no_carry: alarm=%h, expected 0000", {aht[0], aho[0], amt[0], amo[0]});
    end
    set_mode = 1'b0;
  endtask

  task automatic test_reset_mid_ring();
    set_time(23, 59, 59); step();
    set_time(0, 0, 0); step();
    vectors++;
    if (ring_o[0] !== 1'b1 || ring_o[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midnight_ring: ring=%b/%b, expected 1/1", ring_o[0], ring_o[1]);
    end
    reset = 1'b1; step(); reset = 1'b0;
    vectors++;
    if (state_o[0] !== 2'd0 || ring_o[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_ring: state=%0d ring=%b, expected 0 0", state_o[0], ring_o[0]);
    end
    repeat (5) begin
      step();
      vectors++;
      if (ring_o[0] !== 1'b0 || ring_o[1] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL post_reset_quiet: ring=%b/%b, expected 0/0", ring_o[0], ring_o[1]);
      end
    end
    set_time(0, 0, 1); step();
    set_time(0, 0, 0); step();
    vectors++;
    if (ring_o[0] !== 1'b1 || ring_o[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rearm_ring: ring=%b/%b, expected 1/1", ring_o[0], ring_o[1]);
    end
    set_mode = 1'b1; inc_h = 1'b1; inc_m = 1'b1; step(); inc_h = 1'b0; inc_m = 1'b0;
    vectors++;
    if ({aht[0], aho[0], amt[0], amo[0]} !== 16'h0101) begin
      miscompares++;
      $display("[TB] FAIL alarm_0101: alarm=%h, expected 0101", {aht[0], aho[0], amt[0], amo[0]});
    end
    reset = 1'b1; step(); reset = 1'b0; set_mode = 1'b0;
    vectors++;
    if ({aht[1], aho[1], amt[1], amo[1]} !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL alarm_reset: alarm=%h, expected 0000", {aht[1], aho[1], amt[1], amo[1]});
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 499) == 0);
      alarm_en = ($urandom_range(0, 49) != 0);
      set_mode = ($urandom_range(0, 39) == 0);
      inc_h    = 1'($urandom_range(0, 1));
      inc_m    = 1'($urandom_range(0, 1));
      stop     = ($urandom_range(0, 15) == 0);
      snooze   = ($urandom_range(0, 7) == 0);
      tick_1hz = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 3));
      if (r == 0)      set_time(al_h, al_m, 0);
      else if (r == 1) set_time(al_h, al_m, int'($urandom_range(1, 59)));
      else if (r == 2) set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                                int'($urandom_range(0, 59)));
      step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({state_o[k], ring_o[k], aht[k], aho[k], amt[k], amo[k]} !==
            {2'(m_mode[k]), (m_mode[k] == 1), 4'(al_h / 10), 4'(al_h % 10),
             4'(al_m / 10), 4'(al_m % 10)}) begin
          miscompares++;
          $display("[TB] FAIL random n=%0d inst%0d: state=%0d ring=%b alarm=%h, expected state=%0d ring=%b alarm=%02d%02d",
                   n, k, state_o[k], ring_o[k], {aht[k], aho[k], amt[k], amo[k]},
                   m_mode[k], (m_mode[k] == 1), al_h, al_m);
        end
      end
    end
    reset = 1'b0; stop = 1'b0; snooze = 1'b0; tick_1hz = 1'b0;
    inc_h = 1'b0; inc_m = 1'b0; set_mode = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0; set_mode = 1'b0;
    inc_h = 1'b0; inc_m = 1'b0; stop = 1'b0; snooze = 1'b0;
    set_time(0, 0, 0);
    al_h = 0; al_m = 0; prev_match = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_rsec[k] = 0; m_ssec[k] = 0;
    end
    test_reset();
    test_trigger();
    test_auto_stop();
    test_snooze();
    test_stop_wins();
    test_set_mode();
    test_reset_mid_ring();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
